// File: rtl/bm_sample_fifo.sv
// -----------------------------------------------------------------------------
// bm_sample_fifo
//
// Output buffer of the Box-Muller Gaussian generator. Each valid (x0, x1)
// pair is stored as one {x1, x0} FIFO entry. Entries leave as a 16-bit
// ready/valid stream, x0 first and then x1. Pairs that arrive while the FIFO
// is full are dropped rather than stalled. Each drop is counted in a
// saturating counter and raises a sticky overflow flag.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   enable     capture enable; when low, in_valid is ignored entirely
//   in_valid   x0_in/x1_in hold a valid pair this cycle
//   x0_in      first sample of the pair (sent first)
//   x1_in      second sample of the pair
//   out_data   head sample: x0 when phase=0, x1 when phase=1; 0 when idle
//   out_valid  out_data holds a valid sample (FIFO not empty)
//   out_ready  consumer accepts out_data this cycle
//   level      number of stored pairs, 0..DEPTH
//   overflow   sticky: at least one pair dropped since reset or clr_ovf
//   drop_cnt   number of dropped pairs, saturating at 16'hFFFF
//   clr_ovf    clears overflow and drop_cnt (a drop in the same cycle wins)
// -----------------------------------------------------------------------------
module bm_sample_fifo #(
    parameter int DEPTH = 8,   // capacity in pairs, power of two, >= 2
    parameter int AW    = 3    // log2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          in_valid,
    input  logic [15:0]   x0_in,
    input  logic [15:0]   x1_in,
    output logic [15:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [15:0]   drop_cnt,
    input  logic          clr_ovf
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    // Pair storage, entry layout {x1, x0}.
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   level_q,    level_d;
    logic          phase_q,    phase_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic full, empty;
    logic push, drop, xfer, pop;
    logic [31:0] head;

    // Full/empty come from the registered level only. A pop in the same
    // cycle does not free a slot for a push (no write-through).
    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);

    assign push = enable && in_valid && !full;
    assign drop = enable && in_valid &&  full;
    assign xfer = out_valid && out_ready;
    assign pop  = xfer && phase_q;      // the x1 transfer retires the pair

    assign head      = mem[rd_ptr_q];
    assign out_valid = !empty;
    assign out_data  = out_valid ? (phase_q ? head[31:16] : head[15:0]) : 16'h0000;

    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; an unassigned path would infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        phase_d    = phase_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (xfer) begin
            phase_d = !phase_q;
            if (phase_q) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end

        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        // A drop in the same cycle as clr_ovf counts as the first drop
        // after the clear.
        if (clr_ovf) begin
            overflow_d = drop;
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            phase_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: the storage array is deliberately left out of reset. Entries are
    // only read when level says they were written, so reset can stay off the
    // RAM and it maps to plain memory.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {x1_in, x0_in};
        end
    end

endmodule

// File: tb/tb_bm_sample_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for bm_sample_fifo. A queue-based model of pairs, plus an output
// phase bit, predicts every output. The outputs are compared on each falling
// edge. Directed scenarios add literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_bm_sample_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          in_valid;
    logic [15:0]   x0_in, x1_in;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   level;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic          clr_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    bm_sample_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .x0_in     (x0_in),
        .x1_in     (x1_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_q [$];      // stored pairs {x1, x0}, head at index 0
    bit          m_phase = 0;  // 1 once the head x0 has been accepted
    bit          m_ovf   = 0;
    int          m_cnt   = 0;
    bit          cmp_en  = 0;

    always @(posedge clk) begin
        bit m_full, m_drop, m_push, m_xfer;
        if (reset) begin
            m_q.delete();
            m_phase = 0;
            m_ovf   = 0;
            m_cnt   = 0;
        end else begin
            m_full = (m_q.size() == DEPTH);
            m_drop = enable && in_valid && m_full;
            m_push = enable && in_valid && !m_full;
            m_xfer = (m_q.size() > 0) && out_ready;
            if (m_xfer) begin
                if (m_phase) void'(m_q.pop_front());
                m_phase = !m_phase;
            end
            if (m_push) m_q.push_back({x1_in, x0_in});
            if (clr_ovf) begin
                m_ovf = m_drop;
                m_cnt = m_drop ? 1 : 0;
            end else if (m_drop) begin
                m_ovf = 1;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    end

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        logic [15:0] exp_data;
        if (cmp_en) begin
            exp_data = 16'h0000;
            if (m_q.size() > 0) exp_data = m_phase ? m_q[0][31:16] : m_q[0][15:0];
            check("model out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
            check("model out_data",  {16'd0, out_data},  {16'd0, exp_data});
            check("model level",     {28'd0, level},     m_q.size());
            check("model overflow",  {31'd0, overflow},  {31'd0, m_ovf});
            check("model drop_cnt",  {16'd0, drop_cnt},  m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b1; in_valid = 1'b0; x0_in = '0; x1_in = '0; clr_ovf = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0;
        idle_inputs();
        do_reset();
        cmp_en = 1;

        // ---- reset state ----
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset level",     {28'd0, level},     32'd0);
        check("reset out_data",  {16'd0, out_data},  32'd0);
        check("reset overflow",  {31'd0, overflow},  32'd0);
        check("reset drop_cnt",  {16'd0, drop_cnt},  32'd0);

        // ---- single pair, consumer always ready ----
        out_ready = 1'b1;
        in_valid = 1'b1; x0_in = 16'h1234; x1_in = 16'hABCD;
        tick();
        in_valid = 1'b0;
        check("single x0",     {16'd0, out_data}, 32'h1234);
        check("single level1", {28'd0, level},    32'd1);
        tick();
        check("single x1",     {16'd0, out_data}, 32'hABCD);
        check("single level2", {28'd0, level},    32'd1);
        tick();
        check("single level0", {28'd0, level},    32'd0);
        check("single idle",   {31'd0, out_valid}, 32'd0);

        // ---- fill, overflow by two, drain in order ----
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) begin
                check("fill level8",  {28'd0, level},    32'd8);
                check("fill no ovf",  {31'd0, overflow}, 32'd0);
            end
            in_valid = 1'b1; x0_in = 16'h0100 + 16'(i); x1_in = 16'h0200 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        check("ovf level",    {28'd0, level},    32'd8);
        check("ovf flag",     {31'd0, overflow}, 32'd1);
        check("ovf drop_cnt", {16'd0, drop_cnt}, 32'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("drain valid", {31'd0, out_valid}, 32'd1);
            check("drain data",  {16'd0, out_data},
                  (k % 2 == 0) ? 32'h0100 + 32'(k / 2) : 32'h0200 + 32'(k / 2));
            tick();
        end
        check("drain empty", {31'd0, out_valid}, 32'd0);

        // ---- full, phase=1, pop and refused push in the same cycle ----
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; x0_in = 16'h0300 + 16'(i); x1_in = 16'h0400 + 16'(i);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();                                   // x0 of pair 0 accepted
        check("phase1 level", {28'd0, level},    32'd8);
        check("phase1 x1",    {16'd0, out_data}, 32'h0400);
        in_valid = 1'b1; x0_in = 16'hDEAD; x1_in = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        check("popdrop level", {28'd0, level},    32'd7);
        check("popdrop cnt",   {16'd0, drop_cnt}, 32'd3);
        check("popdrop next",  {16'd0, out_data}, 32'h0301);
        for (int i = 0; i < 14; i++) tick();
        check("popdrop drained", {28'd0, level}, 32'd0);

        // ---- random backpressure, push every third cycle ----
        for (int c = 0; c < 60; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (c % 3 == 0);
            x0_in = 16'($urandom); x1_in = 16'($urandom);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 2; i++) tick();
        check("random drained", {28'd0, level}, 32'd0);

        // ---- enable low ignores in_valid ----
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr ovf",  {31'd0, overflow}, 32'd0);
        check("clr cnt",  {16'd0, drop_cnt}, 32'd0);
        enable = 1'b0; in_valid = 1'b1; x0_in = 16'h7777; x1_in = 16'h8888;
        for (int i = 0; i < 20; i++) tick();
        check("disabled level", {28'd0, level},    32'd0);
        check("disabled cnt",   {16'd0, drop_cnt}, 32'd0);
        enable = 1'b1; in_valid = 1'b0;

        // ---- five drops, then clr_ovf together with a drop ----
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; x0_in = 16'h0500 + 16'(i); x1_in = 16'h0600 + 16'(i);
            tick();
        end
        check("five drops", {16'd0, drop_cnt}, 32'd5);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0; in_valid = 1'b0;
        check("clr+drop ovf", {31'd0, overflow}, 32'd1);
        check("clr+drop cnt", {16'd0, drop_cnt}, 32'd1);

        // ---- reset mid-stream with level=5, phase=1 ----
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();      // 3 pairs out, then x0 of the 4th
        out_ready = 1'b0;
        check("pre-reset level", {28'd0, level},    32'd5);
        check("pre-reset x1",    {16'd0, out_data}, 32'h0603);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post-reset level", {28'd0, level},     32'd0);
        check("post-reset valid", {31'd0, out_valid}, 32'd0);
        check("post-reset ovf",   {31'd0, overflow},  32'd0);
        in_valid = 1'b1; x0_in = 16'h5A5A; x1_in = 16'hA5A5;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        check("post-reset x0", {16'd0, out_data}, 32'h5A5A);
        tick();
        check("post-reset x1", {16'd0, out_data}, 32'hA5A5);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bm_sample_fifo.md
Name: bm_sample_fifo

Overview:
Downstream stage of the Box-Muller Gaussian generator. It captures each (x0, x1) sample pair the generator qualifies with valid, and buffers the pairs in a small FIFO. It serialises them onto a single 16-bit ready/valid stream, x0 first and then x1, for the consuming datapath or host interface. Pairs that arrive while the FIFO is full are dropped, counted, and flagged.

Parameters:
DEPTH, 8, FIFO capacity in sample pairs; power of two, minimum 2.
AW, 3, pointer width; must equal log2(DEPTH).

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  capture enable; when low, in_valid is ignored and nothing is dropped or counted
in_valid  input  1  sample pair on x0_in/x1_in is valid this cycle (the generator's valid)
x0_in  input  16  first Gaussian sample of the pair
x1_in  input  16  second Gaussian sample of the pair
out_data  output  16  serialised sample; head x0 when phase=0, head x1 when phase=1
out_valid  output  1  out_data holds a valid sample
out_ready  input  1  consumer accepts out_data this cycle
level  output  AW+1  number of pairs stored, 0..DEPTH
overflow  output  1  sticky flag: at least one pair dropped since reset or the last clr_ovf
drop_cnt  output  16  number of dropped pairs, saturates at 16'hFFFF
clr_ovf  input  1  clears overflow and drop_cnt

Behaviour:
- Reset (synchronous, active-high) gives: wr_ptr=0, rd_ptr=0, level=0, phase=0, out_valid=0, overflow=0, drop_cnt=0.
- out_data is don't-care while out_valid=0. The benches drive and check it as 0 after reset.
- Reset asserted mid-operation discards all stored pairs and any half-sent pair. Memory contents need no reset.
- Storage: DEPTH x 32-bit array, each entry {x1, x0}. wr_ptr and rd_ptr are AW bits and wrap naturally modulo DEPTH.
- full = (level == DEPTH); empty = (level == 0). Both are decoded from the registered level only.
- Push: enable && in_valid && !full. The entry is written at wr_ptr and wr_ptr increments.
- Drop: enable && in_valid && full. Nothing is written, overflow is set to 1, and drop_cnt increments unless it is already 16'hFFFF.
- A push is refused when full even if a pop happens in the same cycle. Full is judged at the start of the cycle; there is no write-through.
- out_valid = !empty, driven combinationally from registered level.
- out_data = phase ? mem[rd_ptr][31:16] : mem[rd_ptr][15:0].
- Transfer occurs when out_valid && out_ready:
  - phase 0 -> phase 1, no pop.
  - phase 1 -> phase 0, rd_ptr increments, pair popped.
- level update: push only +1; pop only -1; push and pop together, unchanged.
- Latency: a pair pushed at edge N into an empty FIFO gives out_valid=1 with out_data=x0 in the cycle after edge N. Its x1 appears the cycle after the x0 transfer.
- Holding: while out_valid && !out_ready, out_data and phase hold stable. No sample is ever skipped or duplicated.
- clr_ovf: overflow is set to 0 and drop_cnt to 0.
  - clr_ovf with a drop in the same cycle gives overflow=1 and drop_cnt=1.
- Throughput: sustained input is at most 1 pair per 2 cycles with out_ready held high. The generator produces 1 pair per cycle, so enable or the FIFO depth must absorb bursts. Excess pairs are dropped, never stalled.
- Summary of the push/pop/drop conditions:
  - enable=0: no push and no drop; the output side continues draining.
  - Push while empty: out_valid goes high the next cycle.
  - Pop of the last pair: out_valid is low the next cycle unless a push occurred in the same cycle.

Test Plan:
- Reset, then push a single pair x0=16'h1234, x1=16'hABCD with out_ready=1 -> out_data 16'h1234 then 16'hABCD on consecutive cycles; level goes 1 then 0; out_valid then drops.
- Push 8 pairs back-to-back with out_ready=0 -> level=8, overflow=0. A 9th and 10th pair -> overflow=1, drop_cnt=2, level stays 8. Then out_ready=1 -> 16 samples out in order x0_0, x1_0 … x1_7 with no gaps, and the dropped pairs never appear.
- FIFO full with phase=1 and out_ready=1, in_valid=1 in the same cycle -> pop occurs, push refused, drop_cnt+1, level=7.
- Toggle out_ready randomly while pushing every 3rd cycle -> out_data stable whenever out_valid && !out_ready. The output sequence is an exact interleave of the input pairs.
- enable=0 with in_valid=1 for 20 cycles -> level=0, drop_cnt=0. Then set drop_cnt=5, assert clr_ovf together with a drop -> overflow=1, drop_cnt=1.
- Reset asserted while level=5 and phase=1 -> the next cycle has level=0, out_valid=0, phase=0. A following push emits its x0 first.
